jk_op_arbiter: RTL



---
 rtl/jk_ctrl_defs.sv | 31 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/jk_op_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/jk_ctrl_defs.sv
// Shared definitions for the JK flop op arbiter: op codes, controller states,
// and the flop next-state rule.
package jk_ctrl_defs;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_SETTLE = 2'b10,
    ST_DONE   = 2'b11
  } jk_state_e;

  // Op is {j,k}; result is what the flop holds after sampling it.
  function automatic logic next_q(input logic q, input logic [1:0] op);
    logic nq;
    case (op)
      OP_HOLD:  nq = q;
      OP_RESET: nq = 1'b0;
      OP_SET:   nq = 1'b1;
      default:  nq = ~q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first unmasked request at or after the
// pointer, searching cyclically. Output is one-hot or zero.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         grant
);

  localparam int PW = $clog2(N);

  logic [N-1:0]  cand;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    cand  = req & ~mask;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(pointer) + i) % N);
      if (!found && cand[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jk_op_arbiter.sv
// Shares one JK flop among NREQ requesters: round-robin grant, one-cycle j/k
// issue, settle window, then ack with a shadow-vs-flop consistency check.
module jk_op_arbiter
  import jk_ctrl_defs::*;
#(
  parameter int NREQ       = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  input  logic              q_in,
  output logic [NREQ-1:0]   gnt,
  output logic              ack,
  output logic              j,
  output logic              k,
  output logic              q_shadow,
  output logic              busy,
  output logic              err
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(SETTLE_CYC + 1);

  jk_state_e     state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] next_ptr;
  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] grant;
  logic [1:0]    sel_op;
  logic [CW-1:0] cnt;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req     (req),
    .mask    (mask),
    .pointer (ptr),
    .grant   (grant)
  );

  always_comb begin
    sel_op = OP_HOLD;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_op = op[2*i +: 2];
    end
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) win_idx = PW'(i);
    end
    next_ptr = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // j/k double as the latched op: they are loaded in IDLE and consumed in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      ack      <= 1'b0;
      j        <= 1'b0;
      k        <= 1'b0;
      q_shadow <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      ptr      <= '0;
      mask     <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mask <= '0;
          if (|grant) begin
            gnt    <= grant;
            {j, k} <= sel_op;
            busy   <= 1'b1;
            state  <= ST_ISSUE;
          end else begin
            gnt    <= '0;
            {j, k} <= 2'b00;
          end
        end
        ST_ISSUE: begin
          q_shadow <= next_q(q_shadow, {j, k});
          {j, k}   <= 2'b00;
          cnt      <= CW'(SETTLE_CYC - 1);
          state    <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            ack   <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          ack   <= 1'b0;
          if (q_in != q_shadow) err <= 1'b1;
          ptr   <= next_ptr;
          mask  <= gnt;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
